// File: rtl/pwm_duty_capture_if.sv
// ============================================================================
// Module      : pwm_duty_capture_if
// Description : PWM input line and measured duty/period results bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pwm_duty_capture_if #(
    parameter int CNT_W  = 17,
    parameter int DUTY_W = 5
) ();
    logic              pwm_in;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic [DUTY_W-1:0] duty_code;
    logic              duty_valid;
    logic              stuck;
    logic              overrun;
    logic              busy;

    // The measuring block is the slave; whatever drives the PWM line and reads results is the master.
    modport slave (
        input  pwm_in,
        output high_cnt, period_cnt, duty_code, duty_valid, stuck, overrun, busy
    );

    modport master (
        output pwm_in,
        input  high_cnt, period_cnt, duty_code, duty_valid, stuck, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/pwm_duty_capture.sv
// ============================================================================
// Module      : pwm_duty_capture
// Description : Measures high time and period of an asynchronous PWM line and
//               quantises the duty cycle to a DUTY_W-bit code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pwm_duty_capture #(
    parameter int CNT_W      = 17,
    parameter int DUTY_W     = 5,
    parameter int MAX_PERIOD = 100000
) (
    input  wire logic          clk,
    input  wire logic          reset_central_n,
    pwm_duty_capture_if.slave  bus
);

    localparam int                ITER_W      = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
    localparam logic [CNT_W-1:0]  c_MAX_CNT   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
    localparam logic [ITER_W-1:0] c_LAST_ITER = ITER_W'(DUTY_W - 1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MEAS    = 2'd1,
        ST_DIV     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t r_state;

    logic r_sync1;
    logic r_sync2;
    logic r_s_d;
    logic w_rise;
    logic w_fall;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hi_lat;

    logic [CNT_W:0]    r_rem;
    logic [CNT_W-1:0]  r_den;
    logic [CNT_W-1:0]  r_num_hi;
    logic [DUTY_W-1:0] r_quo;
    logic [ITER_W-1:0] r_iter;

    logic [CNT_W:0]    w_rem_sh;
    logic              w_ge;
    logic [CNT_W:0]    w_rem_nx;
    logic [DUTY_W-1:0] w_quo_nx;

    logic [CNT_W-1:0]  r_high_cnt;
    logic [CNT_W-1:0]  r_period_cnt;
    logic [DUTY_W-1:0] r_duty_code;
    logic              r_duty_valid;
    logic              r_stuck;
    logic              r_overrun;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset_central_n) begin
        if (!reset_central_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_s_d;
    assign w_fall = ~r_sync2 & r_s_d;

    // Counter reads 1 in the first cycle after a rise, so at the next rise it equals the period
    always_ff @(posedge clk or negedge reset_central_n) begin
        if (!reset_central_n) begin
            r_cnt    <= '0;
            r_hi_lat <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= c_CNT_ONE;
            end else if (r_cnt != c_MAX_CNT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fall) begin
                r_hi_lat <= r_cnt;
            end
        end
    end

    // One restoring-division step: high is always below period, so the quotient fits DUTY_W bits
    assign w_rem_sh = r_rem << 1;
    assign w_ge     = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
    assign w_quo_nx = (r_quo << 1) | DUTY_W'(w_ge);

    always_ff @(posedge clk or negedge reset_central_n) begin
        if (!reset_central_n) begin
            r_state      <= ST_ARM;
            r_rem        <= '0;
            r_den        <= '0;
            r_num_hi     <= '0;
            r_quo        <= '0;
            r_iter       <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_duty_code  <= '0;
            r_duty_valid <= 1'b0;
            r_stuck      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            r_overrun    <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (w_rise) begin
                        r_state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // A rise takes priority over a timeout landing in the same cycle
                    if (w_rise) begin
                        r_rem    <= {1'b0, r_hi_lat};
                        r_den    <= r_cnt;
                        r_num_hi <= r_hi_lat;
                        r_quo    <= '0;
                        r_iter   <= '0;
                        r_state  <= ST_DIV;
                    end else if (r_cnt == c_MAX_CNT) begin
                        r_state <= ST_TIMEOUT;
                    end
                end
                ST_DIV: begin
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end
                    r_rem  <= w_rem_nx;
                    r_quo  <= w_quo_nx;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == c_LAST_ITER) begin
                        r_duty_code  <= w_quo_nx;
                        r_high_cnt   <= r_num_hi;
                        r_period_cnt <= r_den;
                        r_duty_valid <= 1'b1;
                        r_stuck      <= 1'b0;
                        r_state      <= ST_MEAS;
                    end
                end
                ST_TIMEOUT: begin
                    r_stuck      <= 1'b1;
                    r_duty_code  <= r_sync2 ? '1 : '0;
                    r_high_cnt   <= '0;
                    r_period_cnt <= '0;
                    r_duty_valid <= 1'b1;
                    r_state      <= ST_ARM;
                end
                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

    assign bus.high_cnt   = r_high_cnt;
    assign bus.period_cnt = r_period_cnt;
    assign bus.duty_code  = r_duty_code;
    assign bus.duty_valid = r_duty_valid;
    assign bus.stuck      = r_stuck;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state == ST_DIV);

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
// ============================================================================
// Module      : tb_pwm_duty_capture
// Description : Scoreboard bench for pwm_duty_capture with directed PWM patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_duty_capture;

    localparam int CNT_W  = 17;
    localparam int DUTY_W = 5;
    localparam int TB_MAX = 3000;

    typedef struct {
        int h;
        int p;
        int code;
        int stuck;
        int cyc;
    } exp_t;

    logic clk;
    logic reset_central_n;
    int   cyc;
    int   ofs;
    int   n_tests;
    int   n_fail;
    int   ovr_seen;
    int   exp_ovr;
    bit   armed;
    int   last_acc;
    int   prev_h;
    int   prev_p;
    int   prev_code;
    exp_t sb_q[$];
    exp_t mon_e;

    pwm_duty_capture_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus ();

    pwm_duty_capture #(
        .CNT_W      (CNT_W),
        .DUTY_W     (DUTY_W),
        .MAX_PERIOD (TB_MAX)
    ) dut (
        .clk             (clk),
        .reset_central_n (reset_central_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected effect of a rise on the line: close the previous period or report an overrun
    task automatic model_rise();
        exp_t e;
        if (armed) begin
            if (cyc - last_acc >= DUTY_W + 1) begin
                e.h = prev_h; e.p = prev_p; e.code = prev_code; e.stuck = 0;
                e.cyc = cyc + 3 + DUTY_W;
                sb_q.push_back(e);
                last_acc = cyc;
            end else begin
                exp_ovr++;
            end
        end else begin
            armed    = 1'b1;
            last_acc = cyc - 1000;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #(ofs);
    endtask

    task automatic pulse(input int h, input int p, input int code);
        model_rise();
        prev_h = h; prev_p = p; prev_code = code;
        bus.pwm_in = 1'b1;
        repeat (h) step();
        bus.pwm_in = 1'b0;
        repeat (p - h) step();
    endtask

    task automatic hold_high(input int n);
        exp_t e;
        model_rise();
        e.h = 0; e.p = 0; e.code = 31; e.stuck = 1; e.cyc = -1;
        sb_q.push_back(e);
        armed = 1'b0;
        bus.pwm_in = 1'b1;
        repeat (n) step();
        bus.pwm_in = 1'b0;
    endtask

    // Reset lands inside the divide of the rise that opens this pulse
    task automatic pulse_rst(input int h, input int p, input int code);
        model_rise();
        prev_h = h; prev_p = p; prev_code = code;
        bus.pwm_in = 1'b1;
        repeat (4) step();
        chk("busy_in_div", int'(bus.busy), 1);
        reset_central_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        armed = 1'b0;
        chk("rst_high_cnt",   int'(bus.high_cnt),   0);
        chk("rst_period_cnt", int'(bus.period_cnt), 0);
        chk("rst_duty_code",  int'(bus.duty_code),  0);
        chk("rst_duty_valid", int'(bus.duty_valid), 0);
        chk("rst_stuck",      int'(bus.stuck),      0);
        chk("rst_overrun",    int'(bus.overrun),    0);
        chk("rst_busy",       int'(bus.busy),       0);
        repeat (h - 4) step();
        bus.pwm_in = 1'b0;
        repeat (2) step();
        reset_central_n = 1'b1;
        repeat (p - h - 2) step();
    endtask

    always @(negedge clk) begin
        if (reset_central_n) begin
            if (bus.overrun) ovr_seen++;
            if (bus.duty_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got duty_code %0d period %0d, expected no valid (cycle %0d)",
                             bus.duty_code, bus.period_cnt, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("high_cnt",   int'(bus.high_cnt),   mon_e.h);
                    chk("period_cnt", int'(bus.period_cnt), mon_e.p);
                    chk("duty_code",  int'(bus.duty_code),  mon_e.code);
                    chk("stuck",      int'(bus.stuck),      mon_e.stuck);
                    if (mon_e.cyc >= 0) chk("valid_latency", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; ovr_seen = 0; exp_ovr = 0;
        armed = 1'b0; last_acc = 0; prev_h = 0; prev_p = 0; prev_code = 0; ofs = 0;
        bus.pwm_in = 1'b0;
        reset_central_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_high_cnt",   int'(bus.high_cnt),   0);
        chk("reset_period_cnt", int'(bus.period_cnt), 0);
        chk("reset_duty_code",  int'(bus.duty_code),  0);
        chk("reset_duty_valid", int'(bus.duty_valid), 0);
        chk("reset_stuck",      int'(bus.stuck),      0);
        chk("reset_overrun",    int'(bus.overrun),    0);
        chk("reset_busy",       int'(bus.busy),       0);
        reset_central_n = 1'b1;
        repeat (2) step();

        // Basic 20% duty
        repeat (5) pulse(20, 100, 6);
        // Extremes of the code range
        repeat (4) pulse(63, 64, 31);
        repeat (4) pulse(1, 64, 0);
        // Short periods overlapping the divide
        pulse(30, 100, 9);
        repeat (9) pulse(2, 4, 16);
        repeat (2) pulse(50, 100, 16);
        // Stuck-high timeout and recovery
        hold_high(TB_MAX + 5);
        repeat (10) step();
        chk("stuck_sticky",      int'(bus.stuck),     1);
        chk("stuck_code_hold",   int'(bus.duty_code), 31);
        repeat (3) pulse(50, 100, 16);
        chk("stuck_cleared",     int'(bus.stuck),     0);
        // Reset during the divide
        pulse_rst(20, 100, 6);
        repeat (3) pulse(20, 100, 6);
        // Edges placed away from the clock edge
        ofs = 3;
        repeat (4) pulse(250, 1000, 8);

        repeat (30) step();
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("overrun_count",      ovr_seen,    exp_ovr);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
